// File: rtl/dma_channel_priority_arbiter_if.sv
// Pin, register and handshake bundle between the DMA channel arbiter and its surroundings.
// The slave side is the arbiter; the master side drives requests, configuration and HLDA.
interface dma_channel_priority_arbiter_if;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       controllerDisable;
    logic       rotatingPriority;
    logic       dreqActiveLow;
    logic       dackActiveHigh;
    logic       HLDA;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantChannel;
    logic       abortPulse;

    modport master (
        output DREQ, maskReg, requestReg, controllerDisable, rotatingPriority,
               dreqActiveLow, dackActiveHigh, HLDA, serviceDone,
        input  HRQ, DACK, grantValid, grantChannel, abortPulse
    );

    modport slave (
        input  DREQ, maskReg, requestReg, controllerDisable, rotatingPriority,
               dreqActiveLow, dackActiveHigh, HLDA, serviceDone,
        output HRQ, DACK, grantValid, grantChannel, abortPulse
    );
endinterface

// File: rtl/dma_channel_priority_arbiter.sv
// Four-channel DMA request arbiter: fixed or rotating priority, HRQ/HLDA bus-hold handshake,
// DACK generation for the owning channel and abort detection when HLDA drops mid-grant.
module dma_channel_priority_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 1
) (
    input logic CLK,
    input logic RESET_N,
    input logic srst,
    dma_channel_priority_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD_REQ = 2'd1;
    localparam logic [1:0] ST_GRANTED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] dreq_sync_r;
    logic [NUM_CH-1:0] eff_req_s;
    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [1:0]        grant_ch_r;
    logic [1:0]        grant_ch_next_s;
    logic [1:0]        ptr_r;
    logic [1:0]        ptr_next_s;
    logic              abort_next_s;
    logic              abort_r;
    logic              hrq_r;
    logic              grant_valid_r;
    logic [NUM_CH-1:0] dack_onehot_r;

    // Search from the highest-priority channel (0 in fixed mode, the pointer in rotating mode).
    function automatic logic [1:0] pick_winner(input logic [NUM_CH-1:0] req,
                                               input logic              rotating,
                                               input logic [1:0]        ptr);
        logic [1:0] base;
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        base  = rotating ? ptr : 2'd0;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx   = base + 2'(i);
            pick  = (!found && req[idx]) ? idx : pick;
            found = found | req[idx];
        end
        return pick;
    endfunction

    function automatic logic [NUM_CH-1:0] onehot_of(input logic [1:0] ch);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
    endfunction

    // DREQ synchroniser chain.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dreq_sync_r <= '0;
        end else if (srst) begin
            dreq_sync_r <= '0;
        end else begin
            dreq_sync_r[0] <= bus.DREQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dreq_sync_r[i] <= dreq_sync_r[i-1];
            end
        end
    end

    // Software requests bypass both the mask and the DREQ polarity.
    assign eff_req_s = ((dreq_sync_r[SYNC_STAGES-1] ^ {NUM_CH{bus.dreqActiveLow}}) & ~bus.maskReg)
                       | bus.requestReg;

    // Next-state, winner latch, pointer and abort decision.
    always_comb begin
        state_next_s    = state_r;
        grant_ch_next_s = grant_ch_r;
        ptr_next_s      = ptr_r;
        abort_next_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((|eff_req_s) && !bus.controllerDisable) begin
                    state_next_s = ST_HOLD_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD_REQ: begin
                if (bus.HLDA) begin
                    if (|eff_req_s) begin
                        state_next_s    = ST_GRANTED;
                        grant_ch_next_s = pick_winner(eff_req_s, bus.rotatingPriority, ptr_r);
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end else if (!(|eff_req_s)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD_REQ;
                end
            end
            ST_GRANTED: begin
                // serviceDone wins over a simultaneous HLDA drop: the transfer completed.
                if (bus.serviceDone) begin
                    state_next_s = ST_RELEASE;
                    ptr_next_s   = grant_ch_r + 2'd1;
                end else if (!bus.HLDA) begin
                    state_next_s = ST_RELEASE;
                    abort_next_s = 1'b1;
                end else begin
                    state_next_s = ST_GRANTED;
                end
            end
            ST_RELEASE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered output decode.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r       <= ST_IDLE;
            grant_ch_r    <= 2'd0;
            ptr_r         <= 2'd0;
            abort_r       <= 1'b0;
            hrq_r         <= 1'b0;
            grant_valid_r <= 1'b0;
            dack_onehot_r <= '0;
        end else if (srst) begin
            state_r       <= ST_IDLE;
            grant_ch_r    <= 2'd0;
            ptr_r         <= 2'd0;
            abort_r       <= 1'b0;
            hrq_r         <= 1'b0;
            grant_valid_r <= 1'b0;
            dack_onehot_r <= '0;
        end else begin
            state_r       <= state_next_s;
            grant_ch_r    <= grant_ch_next_s;
            ptr_r         <= ptr_next_s;
            abort_r       <= abort_next_s;
            hrq_r         <= (state_next_s == ST_HOLD_REQ) || (state_next_s == ST_GRANTED);
            grant_valid_r <= (state_next_s == ST_GRANTED);
            dack_onehot_r <= (state_next_s == ST_GRANTED) ? onehot_of(grant_ch_next_s) : '0;
        end
    end

    // DACK polarity is applied after the register so a command change is seen at once.
    assign bus.DACK         = dack_onehot_r ^ {NUM_CH{~bus.dackActiveHigh}};
    assign bus.HRQ          = hrq_r;
    assign bus.grantValid   = grant_valid_r;
    assign bus.grantChannel = grant_ch_r;
    assign bus.abortPulse   = abort_r;

endmodule
